zbt_frame_writer: RTL
=====================

// Module: zbt_frame_writer
// PURPOSE
//  Downstream of zbt_image_writer: takes each packed 36-bit ZBT word and its strobe,
//  buffers it in a small FIFO and writes it to ZBT SRAM at sequential addresses.
//  The ZBT port is time-shared with the display read path; writes issue only on
//  wr_grant cycles. One frame = FRAME_WORDS writes from BASE_ADDR, then idle until
//  the next frame_start.
// PARAMETERS
//  ADDR_WIDTH   19     ZBT address width
//  BASE_ADDR    0      address of first word of frame
//  FRAME_WORDS  19200  words per frame (320x240 8-bit pixels / 4 per word)
//  FIFO_DEPTH   4      buffer entries (power of 2)
// PORTS
//  clk             in   1           system clock
//  reset           in   1           asynchronous, active-high reset
//  frame_start     in   1           1-cycle pulse: begin/restart frame
//  new_input       in   1           1-cycle strobe: image_data_zbt valid
//  image_data_zbt  in   36          packed word from zbt_image_writer
//  wr_grant        in   1           ZBT port free for a write this cycle
//  zbt_we          out  1           write enable, registered
//  zbt_addr        out  ADDR_WIDTH  write address, registered
//  zbt_write_data  out  36          write data, registered
//  frame_done      out  1           1-cycle pulse after last word written
//  overflow        out  1           sticky: word dropped, FIFO full
//  busy            out  1           1 while state ACTIVE
// BEHAVIOUR
//  Reset (async, any time): state IDLE, FIFO empty, index 0; zbt_we=0,
//   zbt_addr=BASE_ADDR, zbt_write_data=0, frame_done=0, overflow=0, busy=0.
//  FSM IDLE: new_input ignored. frame_start -> ACTIVE: index=0, FIFO flushed,
//   overflow cleared.
//  FSM ACTIVE: push on new_input if not full or popping same cycle; new_input
//   while full and not popping -> word dropped, overflow=1 (sticky until
//   frame_start/reset).
//   Pop when wr_grant && !empty: next edge sets zbt_we=1,
//   zbt_addr=BASE_ADDR+index, zbt_write_data=head word; index++. No pop -> zbt_we=0.
//   Latency: new_input at edge k, wr_grant at edge k+1 -> zbt_we high after k+2.
//   Push and pop same cycle allowed at any occupancy incl. full; count unchanged.
//   Pop with index==FRAME_WORDS-1: final write; next edge frame_done=1 one cycle,
//   state -> IDLE, FIFO flushed; extra words ignored.
//   Pops stop once FRAME_WORDS words are written; index never exceeds FRAME_WORDS-1.
//  frame_start in ACTIVE: restart. FIFO flushed, index=0, overflow cleared. Any
//   same-cycle new_input is dropped. The pending registered write already latched
//   still completes.
//  frame_start same cycle as final pop: final write issues, frame_done pulses,
//   state stays ACTIVE with index=0.
//  zbt_addr holds its last value when zbt_we=0.
// TESTING
//  1 frame_start; words 0xA,0xB,0xC,0xD, wr_grant=1 -> we at addr 0..3, data in order
//  2 wr_grant=0, 5 strobes -> 4 buffered, overflow=1; grant=1 -> 4 writes, 5th absent
//  3 FRAME_WORDS=8, 9 words -> 8 writes addr 0..7, frame_done 1 cycle, busy=0
//  4 frame_start after 3 writes -> next write at BASE_ADDR, overflow cleared
//  5 reset after 2 writes -> all outputs reset values, new_input ignored
//  6 FIFO full, new_input+wr_grant same cycle -> no overflow, order kept

Source files
------------

// File: rtl/zbt_frame_writer.sv
// Buffers packed 36-bit pixel words from zbt_image_writer in a small FIFO and
// writes them to ZBT SRAM at sequential addresses on wr_grant cycles, one frame at a time.
module zbt_frame_writer #(
    parameter int ADDR_WIDTH  = 19,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_WORDS = 19200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  new_input,
    input  logic [35:0]           image_data_zbt,
    input  logic                  wr_grant,
    output logic                  zbt_we,
    output logic [ADDR_WIDTH-1:0] zbt_addr,
    output logic [35:0]           zbt_write_data,
    output logic                  frame_done,
    output logic                  overflow,
    output logic                  busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t           state;
    logic [35:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] index;

    logic active;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic last_pop;
    logic push;
    logic drop;

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    // Words arriving with frame_start belong to neither frame and are discarded.
    assign active     = (state == ACTIVE);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign pop        = active && wr_grant && !fifo_empty;
    assign last_pop   = pop && (index == LAST_IDX);
    assign push       = active && !frame_start && new_input && (!fifo_full || pop);
    assign drop       = active && !frame_start && new_input && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= image_data_zbt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            index          <= '0;
            zbt_we         <= 1'b0;
            zbt_addr       <= BASE;
            zbt_write_data <= '0;
            frame_done     <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            zbt_we     <= pop;
            frame_done <= last_pop;
            if (pop) begin
                zbt_addr       <= BASE + ADDR_WIDTH'(index);
                zbt_write_data <= fifo_mem[rd_ptr];
            end

            // A write popped this cycle still goes out even when the frame restarts.
            if (frame_start) begin
                state    <= ACTIVE;
                busy     <= 1'b1;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                index    <= '0;
                overflow <= 1'b0;
            end else if (last_pop) begin
                state  <= IDLE;
                busy   <= 1'b0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                index  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    index  <= index + IDX_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule
